// File: rtl/chaos_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : chaos_reset_sequencer_if
// Brief    : Request/status bundle between the chaos-reset PIO and sequencer.
// Revision : 1.0
// ============================================================================
interface chaos_reset_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             req_in;
    logic [CNT_W-1:0] pulse_len;
    logic             chaos_rst;
    logic             chaos_en;
    logic             busy;
    logic [7:0]       done_count;

    modport master (
        output req_in, pulse_len,
        input  chaos_rst, chaos_en, busy, done_count
    );

    modport slave (
        input  req_in, pulse_len,
        output chaos_rst, chaos_en, busy, done_count
    );
endinterface
`default_nettype wire

// File: rtl/chaos_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : chaos_reset_sequencer
// Brief    : Turns a PIO request edge into reset pulse, settle gap, run enable.
// Revision : 1.0
// ============================================================================
module chaos_reset_sequencer #(
    parameter int PULSE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  wire                      clk,
    input  wire                      reset,
    chaos_reset_sequencer_if.slave   bus
);
    localparam logic [CNT_W-1:0] c_PULSE_LEN  = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] c_SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_req_d;
    logic             r_rst;
    logic             r_en;
    logic             r_busy;
    logic [7:0]       r_done;

    logic             w_trig;
    logic [CNT_W-1:0] w_len_ld;

    assign w_trig   = bus.req_in & ~r_req_d;
    // Counter holds cycles remaining minus one, so a phase of N cycles loads N-1.
    assign w_len_ld = ((bus.pulse_len != '0) ? bus.pulse_len : c_PULSE_LEN) - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_req_d   <= 1'b1;
            r_rst     <= 1'b1;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 8'd0;
        end else begin
            r_req_d <= bus.req_in;
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_trig) begin
                        r_state <= S_ASSERT;
                        r_cnt   <= w_len_ld;
                        r_rst   <= 1'b1;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (w_trig) begin
                        r_pending <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= c_SETTLE_LD;
                        r_rst   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        // A restart request skips RUN entirely and is not counted.
                        if (r_pending || w_trig) begin
                            r_state   <= S_ASSERT;
                            r_cnt     <= w_len_ld;
                            r_pending <= 1'b0;
                            r_rst     <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= r_done + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_trig) begin
                            r_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.chaos_rst  = r_rst;
    assign bus.chaos_en   = r_en;
    assign bus.busy       = r_busy;
    assign bus.done_count = r_done;
endmodule
`default_nettype wire

// File: tb/tb_chaos_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chaos_reset_sequencer
// Brief    : Scoreboard + vector-table bench for chaos_reset_sequencer.
// Revision : 1.0
// ============================================================================
module tb_chaos_reset_sequencer;
    localparam int PULSE  = 16;
    localparam int SETTLE = 64;

    logic clk;
    logic rst_in;

    chaos_reset_sequencer_if #(.CNT_W(16)) bus ();

    chaos_reset_sequencer #(
        .PULSE_CYCLES  (PULSE),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .reset (rst_in),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase plus cycles left in that phase.
    int          m_phase;   // 0 idle, 1 assert, 2 settle, 3 run
    int          m_left;
    bit          m_pend;
    bit          m_reqd;
    logic [7:0]  m_done;
    logic [10:0] exp_q[$];

    function automatic logic [10:0] model_out();
        logic r, e, b;
        r = (m_phase == 0) || (m_phase == 1);
        e = (m_phase == 3);
        b = (m_phase == 1) || (m_phase == 2);
        return {r, e, b, m_done};
    endfunction

    function automatic int plen_n();
        return (bus.pulse_len == 16'd0) ? PULSE : int'(bus.pulse_len);
    endfunction

    task automatic model_edge();
        bit trig;
        if (rst_in) begin
            m_phase = 0; m_left = 0; m_pend = 0; m_reqd = 1; m_done = 8'd0;
            return;
        end
        trig   = bus.req_in && !m_reqd;
        m_reqd = bus.req_in;
        if (m_phase == 0 || m_phase == 3) begin
            if (trig) begin m_phase = 1; m_left = plen_n(); end
        end else begin
            if (trig) m_pend = 1;
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_phase == 1) begin
                    m_phase = 2; m_left = SETTLE;
                end else if (m_pend) begin
                    m_phase = 1; m_left = plen_n(); m_pend = 0;
                end else begin
                    m_phase = 3; m_done = m_done + 8'd1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] dut_out();
        return {bus.chaos_rst, bus.chaos_en, bus.busy, bus.done_count};
    endfunction

    // One clock: push model prediction, advance, pop and compare against the DUT.
    task automatic step();
        logic [10:0] e;
        model_edge();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("scoreboard", 32'(dut_out()), 32'(e));
    endtask

    typedef struct {
        logic        req;
        logic [15:0] plen;
        int          cycles;
        logic [10:0] exp;   // {rst, en, busy, done_count} after the row
    } vec_t;

    vec_t vecs[12];

    initial begin
        int cyc;
        bit en_seen;

        vecs[0]  = '{1'b0, 16'd0,   5,  {3'b100, 8'd0}};
        vecs[1]  = '{1'b1, 16'd0,   1,  {3'b101, 8'd0}};
        vecs[2]  = '{1'b1, 16'd0,   15, {3'b101, 8'd0}};
        vecs[3]  = '{1'b1, 16'd0,   1,  {3'b001, 8'd0}};
        vecs[4]  = '{1'b1, 16'd0,   63, {3'b001, 8'd0}};
        vecs[5]  = '{1'b1, 16'd0,   1,  {3'b010, 8'd1}};
        vecs[6]  = '{1'b0, 16'd0,   3,  {3'b010, 8'd1}};
        vecs[7]  = '{1'b1, 16'd3,   1,  {3'b101, 8'd1}};
        vecs[8]  = '{1'b1, 16'd3,   2,  {3'b101, 8'd1}};
        vecs[9]  = '{1'b1, 16'd3,   1,  {3'b001, 8'd1}};
        vecs[10] = '{1'b1, 16'd100, 63, {3'b001, 8'd1}};
        vecs[11] = '{1'b1, 16'd100, 1,  {3'b010, 8'd2}};

        m_phase = 0; m_left = 0; m_pend = 0; m_reqd = 1; m_done = 8'd0;
        rst_in        = 1'b1;
        bus.req_in    = 1'b0;
        bus.pulse_len = 16'd0;
        repeat (3) step();
        chk("reset_values", 32'(dut_out()), 32'({3'b100, 8'd0}));
        rst_in = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus.req_in    = vecs[i].req;
            bus.pulse_len = vecs[i].plen;
            repeat (vecs[i].cycles) step();
            chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
        end

        // Three triggers while busy collapse into one restart.
        bus.pulse_len = 16'd4;
        bus.req_in = 1'b0; step();
        bus.req_in = 1'b1; step();
        cyc = 1;
        en_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.req_in = k[0];
            step(); cyc++;
            if (bus.chaos_en) en_seen = 1'b1;
        end
        while (!bus.chaos_en && cyc < 400) begin
            step(); cyc++;
        end
        chk("restart_en_not_early", 32'(en_seen), 32'(0));
        chk("restart_latency", 32'(cyc), 32'(4 + SETTLE + 4 + SETTLE + 1));
        chk("restart_done", 32'(bus.done_count), 32'(3));

        // Request held high across reset release must not trigger.
        rst_in = 1'b1; bus.req_in = 1'b1;
        repeat (2) step();
        rst_in = 1'b0;
        repeat (10) step();
        chk("held_req_idle", 32'(dut_out()), 32'({3'b100, 8'd0}));
        bus.req_in = 1'b0; step();
        bus.pulse_len = 16'd0;
        bus.req_in = 1'b1; step();
        chk("fresh_edge_busy", 32'(bus.busy), 32'(1));

        // Reset in the middle of a sequence.
        repeat (9) step();
        rst_in = 1'b1; step();
        chk("mid_reset", 32'(dut_out()), 32'({3'b100, 8'd0}));
        rst_in = 1'b0; bus.req_in = 1'b0;

        // 256 shortest sequences wrap the completion counter.
        bus.pulse_len = 16'd1;
        for (int s = 0; s < 256; s++) begin
            bus.req_in = 1'b0; step();
            bus.req_in = 1'b1; step();
            cyc = 0;
            while (!bus.chaos_en && cyc < 200) begin
                step(); cyc++;
            end
            if (s == 0)   chk("short_seq_len", 32'(cyc), 32'(1 + SETTLE));
            if (s == 254) chk("done_255", 32'(bus.done_count), 32'(255));
        end
        chk("done_wrap", 32'(bus.done_count), 32'(0));
        chk("final_run", 32'({bus.chaos_rst, bus.chaos_en, bus.busy}), 32'(3'b010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
